func_sweep_ctrl: RTL and testbench
==================================

Name: func_sweep_ctrl

Overview:
Sequencer that exercises an external combinational function block with N_IN inputs and 1 output, such as the lab logic functions.
- Drives every input vector 0..2**N_IN-1 in turn.
- Waits a fixed settle time, samples the function output and builds the captured truth table.
- Compares each sample against a caller-supplied expected table and reports mismatches.
- Sits between a test/control host (start/done handshake) and the function block under exercise.

Parameters:
N_IN, 4, number of function inputs; legal 1..6
SETTLE, 2, cycles between applying a vector and sampling fn_out; legal >=1

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  cancel a running sweep
expected  in  2**N_IN  golden truth table; bit i = expected output for vector i; latched on accepted start
fn_vec  out  N_IN  input vector driven to the function block
fn_out  in  1  function block output
busy  out  1  high in WAIT/SAMPLE
done  out  1  one-cycle pulse on sweep completion
truth  out  2**N_IN  captured truth table
mismatch_cnt  out  N_IN+1  number of vectors where fn_out != expected bit
pass  out  1  1 when the last completed sweep had zero mismatches

Behaviour:
- Reset (rst_n=0, async): state=IDLE; fn_vec=0, busy=0, done=0, truth=0, mismatch_cnt=0, pass=0, exp_q=0, settle counter=0.
- States: IDLE, WAIT, SAMPLE, FINISH. All outputs are registered; busy and done decode the state only.
- IDLE, start=1 and abort=0 at edge E0:
  - exp_q<=expected, fn_vec<=0, truth<=0, mismatch_cnt<=0, pass<=0.
  - cnt<=SETTLE-1, go to WAIT.
- IDLE, start=1 and abort=1: remain in IDLE.
- WAIT: if cnt==0 go to SAMPLE, else cnt<=cnt-1. WAIT lasts exactly SETTLE cycles.
- SAMPLE:
  - truth[fn_vec]<=fn_out.
  - If fn_out!=exp_q[fn_vec], mismatch_cnt<=mismatch_cnt+1.
  - If fn_vec==2**N_IN-1: pass<=(final mismatch count==0), go to FINISH.
  - Otherwise fn_vec<=fn_vec+1, cnt<=SETTLE-1, go to WAIT.
- FINISH: done=1 for exactly this cycle, busy=0. Next state is IDLE unconditionally; start in FINISH is ignored.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - FINISH is entered at edge E0+2**N_IN*(SETTLE+1). With defaults that is E0+48.
  - A new sweep can be accepted at the earliest at the edge after done falls.
- fn_vec holds its final value (2**N_IN-1) after completion. It does not wrap; it is cleared only by an accepted start or by reset.
- start while busy or in FINISH: ignored, no effect on the sweep in progress.
- abort=1 in WAIT or SAMPLE:
  - Next state is IDLE. Abort has priority over the sample.
  - No done pulse, pass<=0.
  - truth, mismatch_cnt and fn_vec keep their partial values.
- abort in IDLE or FINISH: no effect.
- Reset mid-sweep: immediate return to reset values, no done pulse.
- mismatch_cnt is sized so that 2**N_IN mismatches fit without overflow.
- expected may change after start is accepted; only exp_q is used.

Decomposition:
- Package func_sweep_pkg holds:
  - state enum typedef (IDLE, WAIT, SAMPLE, FINISH);
  - localparam function for table width 2**N_IN;
  - localparam function for count width N_IN+1.
- No sub-module is needed. The settle down-counter and the FSM live in one module.

Test Plan:
1. Bench model fn_out = fn_vec[0]^fn_vec[3]; defaults; expected=16'h55AA; start pulse -> busy for 48 cycles, done at E0+48, truth=16'h55AA, mismatch_cnt=0, pass=1.
2. Same model, expected=16'h55AB -> mismatch_cnt=1, pass=0, truth=16'h55AA.
3. Same model, expected=16'hAA55 -> mismatch_cnt=16 (5'b10000, no overflow), pass=0.
4. Abort asserted at E0+20 -> busy=0 next cycle, no done pulse, pass=0. Restart with expected=16'h55AA -> pass=1 at the new E0+48.
5. start pulsed repeatedly during a sweep and again in the FINISH cycle -> exactly one done, sweep timing unchanged. rst_n pulled low at E0+30 -> all outputs zero immediately, no done.
6. SETTLE=1, N_IN=3, fn_out produced through a one-cycle register, expected = matching 8-bit table -> done at E0+16, pass=1. The same model with a two-cycle delay gives pass=0.

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and width helpers for the
// truth-table sweep sequencer.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_FINISH
  } sweep_state_t;

  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/func_sweep_ctrl.sv
// Walks every input vector of a combinational
// function, samples it and scores a truth table.
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [tbl_w(N_IN)-1:0]     expected,
  output logic [N_IN-1:0]            fn_vec,
  input  logic                       fn_out,
  output logic                       busy,
  output logic                       done,
  output logic [tbl_w(N_IN)-1:0]     truth,
  output logic [cnt_w(N_IN)-1:0]     mismatch_cnt,
  output logic                       pass
);

  localparam int TW = tbl_w(N_IN);
  localparam int MW = cnt_w(N_IN);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  sweep_state_t r_state;
  sweep_state_t w_state;

  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] w_vec;
  logic [TW-1:0]   r_truth;
  logic [TW-1:0]   w_truth;
  logic [MW-1:0]   r_mcnt;
  logic [MW-1:0]   w_mcnt;
  logic            r_pass;
  logic            w_pass;
  logic [TW-1:0]   r_exp;
  logic [TW-1:0]   w_exp;
  logic            w_miss;
  logic [MW-1:0]   w_mcnt_inc;

  assign w_miss     = fn_out != r_exp[r_vec];
  assign w_mcnt_inc = r_mcnt + {{(MW-1){1'b0}}, w_miss};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_truth <= '0;
      r_mcnt  <= '0;
      r_pass  <= 1'b0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_vec   <= w_vec;
      r_truth <= w_truth;
      r_mcnt  <= w_mcnt;
      r_pass  <= w_pass;
      r_exp   <= w_exp;
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_vec   = r_vec;
    w_truth = r_truth;
    w_mcnt  = r_mcnt;
    w_pass  = r_pass;
    w_exp   = r_exp;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_exp   = expected;
          w_vec   = '0;
          w_truth = '0;
          w_mcnt  = '0;
          w_pass  = 1'b0;
          w_cnt   = CNT_LOAD;
          w_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_pass  = 1'b0;
          w_state = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state = ST_SAMPLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_pass  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_truth[r_vec] = fn_out;
          w_mcnt         = w_mcnt_inc;
          if (r_vec == VEC_LAST) begin
            w_pass  = (w_mcnt_inc == '0);
            w_state = ST_FINISH;
          end else begin
            w_vec   = r_vec + 1'b1;
            w_cnt   = CNT_LOAD;
            w_state = ST_WAIT;
          end
        end
      end
      ST_FINISH: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state == ST_WAIT) ||
                (r_state == ST_SAMPLE);
  assign done = (r_state == ST_FINISH);

  assign fn_vec       = r_vec;
  assign truth        = r_truth;
  assign mismatch_cnt = r_mcnt;
  assign pass         = r_pass;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for the sweep sequencer:
// default config plus a small registered-function config.
module tb_func_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [3:0]  fn_vec;
  logic        fn_out;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  logic        s_start;
  logic [7:0]  s_expected;
  logic [2:0]  s_fn_vec;
  logic        s_fn_out;
  logic        s_busy;
  logic        s_done;
  logic [7:0]  s_truth;
  logic [3:0]  s_mcnt;
  logic        s_pass;
  logic        s_d1;
  logic        s_d2;
  logic        s_dsel;

  int n_tests;
  int n_fail;

  func_sweep_ctrl #(.N_IN(4), .SETTLE(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .fn_vec       (fn_vec),
    .fn_out       (fn_out),
    .busy         (busy),
    .done         (done),
    .truth        (truth),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  func_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (s_start),
    .abort        (1'b0),
    .expected     (s_expected),
    .fn_vec       (s_fn_vec),
    .fn_out       (s_fn_out),
    .busy         (s_busy),
    .done         (s_done),
    .truth        (s_truth),
    .mismatch_cnt (s_mcnt),
    .pass         (s_pass)
  );

  assign fn_out = fn_vec[0] ^ fn_vec[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d1 <= 1'b0;
      s_d2 <= 1'b0;
    end else begin
      s_d1 <= ^s_fn_vec;
      s_d2 <= s_d1;
    end
  end

  assign s_fn_out = s_dsel ? s_d2 : s_d1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_main(input logic [15:0] e,
                          output int cyc,
                          output int nbusy);
    expected = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expected = ~e;
    cyc = 0;
    nbusy = 0;
    while (!done && cyc < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({busy, done, pass, fn_vec, truth, mismatch_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b pass=%b vec=%h truth=%h mc=%h, want all 0",
               busy, done, pass, fn_vec, truth, mismatch_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass_sweep;
    int cyc, nb;
    run_main(16'h55AA, cyc, nb);
    n_tests++;
    if (cyc !== 48) begin
      n_fail++;
      $display("FAIL pass_done_time: got %0d want 48", cyc);
    end
    n_tests++;
    if (nb !== 48) begin
      n_fail++;
      $display("FAIL pass_busy_cycles: got %0d want 48", nb);
    end
    n_tests++;
    if ({truth, mismatch_cnt, pass, fn_vec} !== {16'h55AA, 5'd0, 1'b1, 4'hF}) begin
      n_fail++;
      $display("FAIL pass_result: truth=%h mc=%0d pass=%b vec=%h want 55aa 0 1 f",
               truth, mismatch_cnt, pass, fn_vec);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || fn_vec !== 4'hF) begin
      n_fail++;
      $display("FAIL done_one_cycle: done=%b busy=%b vec=%h want 0 0 f",
               done, busy, fn_vec);
    end
  endtask

  task automatic test_one_mismatch;
    int cyc, nb;
    run_main(16'h55AB, cyc, nb);
    n_tests++;
    if (cyc !== 48 || truth !== 16'h55AA || mismatch_cnt !== 5'd1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL one_mismatch: cyc=%0d truth=%h mc=%0d pass=%b want 48 55aa 1 0",
               cyc, truth, mismatch_cnt, pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_mismatch;
    int cyc, nb;
    run_main(16'hAA55, cyc, nb);
    n_tests++;
    if (cyc !== 48 || mismatch_cnt !== 5'b10000 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL all_mismatch: cyc=%0d mc=%b pass=%b want 48 10000 0",
               cyc, mismatch_cnt, pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int cyc, nb, nd;
    expected = 16'h55AA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b pass=%b want 0 0 0",
               busy, done, pass);
    end
    n_tests++;
    if (truth !== 16'h002A || fn_vec !== 4'd6 || mismatch_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_partial: truth=%h vec=%0d mc=%0d want 002a 6 0",
               truth, fn_vec, mismatch_cnt);
    end
    nd = 0;
    repeat (60) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: active cycles=%0d want 0", nd);
    end
    run_main(16'h55AA, cyc, nb);
    n_tests++;
    if (cyc !== 48 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: cyc=%0d pass=%b want 48 1", cyc, pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int cyc, nd;
    expected = 16'h55AA;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 100) begin
      start = cyc[0];
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b1;
    n_tests++;
    if (cyc !== 48 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_timing: cyc=%0d pass=%b want 48 1", cyc, pass);
    end
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    repeat (60) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (nd !== 0 || fn_vec !== 4'hF) begin
      n_fail++;
      $display("FAIL finish_start: active=%0d vec=%h want 0 f", nd, fn_vec);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    expected = 16'h55AA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, pass, fn_vec, truth, mismatch_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b pass=%b vec=%h truth=%h mc=%h, want all 0",
               busy, done, pass, fn_vec, truth, mismatch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (60) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: active=%0d want 0", nd);
    end
  endtask

  task automatic run_small(input logic dsel, output int cyc);
    s_dsel = dsel;
    s_expected = 8'h96;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_small_config;
    int cyc;
    run_small(1'b0, cyc);
    n_tests++;
    if (cyc !== 16 || s_pass !== 1'b1 || s_truth !== 8'h96 || s_mcnt !== 4'd0) begin
      n_fail++;
      $display("FAIL small_1dly: cyc=%0d pass=%b truth=%h mc=%0d want 16 1 96 0",
               cyc, s_pass, s_truth, s_mcnt);
    end
    @(posedge clk); #1;
    run_small(1'b1, cyc);
    n_tests++;
    if (cyc !== 16 || s_pass !== 1'b0 || s_mcnt == 4'd0) begin
      n_fail++;
      $display("FAIL small_2dly: cyc=%0d pass=%b mc=%0d want 16 0 nonzero",
               cyc, s_pass, s_mcnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    expected = '0;
    s_start = 1'b0;
    s_expected = '0;
    s_dsel = 1'b0;
    test_reset;
    test_pass_sweep;
    test_one_mismatch;
    test_all_mismatch;
    test_abort;
    test_start_ignored;
    test_reset_mid;
    test_small_config;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
